// File: rtl/seq_alu_flags_pkg.sv
// seq_alu_pkg: op encodings, FSM states and flag bundle shared by the sequential flag ALU
package seq_alu_pkg;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef struct packed {
      logic s;
      logic zr;
      logic cy;
      logic p;
      logic v;
   } flags_t;
endpackage

// File: rtl/seq_alu_flags_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit a+b+cin
// ports: a, b, cin in; sum, cout, c_msb (carry into the top bit) out
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);
   logic [CHUNK:0] full;
   always_comb begin
      full  = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
      sum   = full[CHUNK-1:0];
      cout  = full[CHUNK];
      c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
   end
endmodule

// File: rtl/seq_alu_flags.sv
// seq_alu_flags: multi-cycle ADD/SUB/ADC/SBB producing z and S/ZR/CY/P/V flags
// ports: clk, rst (async, active high); in_valid/in_ready, op, x, y accept an operation;
// out_valid/out_ready, z, s, zr, cy, p, v return the result.
// SEQ_ALU_AUX_CARRY_EN adds output ac (carry/borrow out of bit 3).
module seq_alu_flags
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             s,
   output logic             zr,
   output logic             cy,
   output logic             p,
`ifdef SEQ_ALU_AUX_CARRY_EN
   output logic             v,
   output logic             ac
`else
   output logic             v
`endif
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = WIDTH - CHUNK;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, z_q, z_d;
   logic [RW-1:0]    res_q, res_d;
   logic             carry_q, carry_d, sub_q, sub_d, cf_q, cf_d;
   flags_t           flags_q, flags_d;
   logic [CHUNK-1:0] sum;
   logic             cout, c_msb, last;
   logic [WIDTH-1:0] full;
   // Operands shift right one chunk per cycle so the adder always sees the low chunk;
   // finished slices shift in from the top of res_q.
   chunk_adder #(.CHUNK(CHUNK)) u_add (
      .a(xr_q[CHUNK-1:0]), .b(yr_q[CHUNK-1:0]), .cin(carry_q),
      .sum(sum), .cout(cout), .c_msb(c_msb)
   );
   assign full = {sum, res_q};
   assign last = cnt_q == CW'(N-1);
`ifdef SEQ_ALU_AUX_CARRY_EN
   localparam int AK = 3 % CHUNK;
   localparam int AC = 3 / CHUNK;
   logic [AK+1:0] aux_sum;
   logic          aux_now, aux_sel, ac_t_q, ac_t_d, ac_q, ac_d;
   assign aux_sum = {1'b0, xr_q[AK:0]} + {1'b0, yr_q[AK:0]} + (AK+2)'(carry_q);
   assign aux_now = aux_sum[AK+1] ^ sub_q;
   assign aux_sel = cnt_q == CW'(AC);
   assign ac      = ac_q;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      res_d   = res_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      cf_d    = cf_q;
      z_d     = z_q;
      flags_d = flags_q;
`ifdef SEQ_ALU_AUX_CARRY_EN
      ac_t_d  = ac_t_q;
      ac_d    = ac_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            xr_d    = x;
            yr_d    = op[0] ? ~y : y;
            sub_d   = op[0];
            carry_d = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : (op == OP_ADC) ? cf_q : ~cf_q;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            xr_d    = xr_q >> CHUNK;
            yr_d    = yr_q >> CHUNK;
            res_d   = full[WIDTH-1:CHUNK];
            carry_d = cout;
            cnt_d   = cnt_q + CW'(1);
`ifdef SEQ_ALU_AUX_CARRY_EN
            ac_t_d  = aux_sel ? aux_now : ac_t_q;
`endif
            if (last) begin
               z_d     = full;
               flags_d = {full[WIDTH-1], ~|full, cout ^ sub_q, ~^full, c_msb ^ cout};
               state_d = DONE;
`ifdef SEQ_ALU_AUX_CARRY_EN
               ac_d    = aux_sel ? aux_now : ac_t_q;
`endif
            end
         end
         DONE: if (out_ready) begin
            cf_d    = flags_q.cy;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         xr_q    <= '0;
         yr_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         cf_q    <= 1'b0;
         z_q     <= '0;
         flags_q <= '0;
`ifdef SEQ_ALU_AUX_CARRY_EN
         ac_t_q  <= 1'b0;
         ac_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         cf_q    <= cf_d;
         z_q     <= z_d;
         flags_q <= flags_d;
`ifdef SEQ_ALU_AUX_CARRY_EN
         ac_t_q  <= ac_t_d;
         ac_q    <= ac_d;
`endif
      end
   end
   assign in_ready           = state_q == IDLE;
   assign out_valid          = state_q == DONE;
   assign z                  = z_q;
   assign {s, zr, cy, p, v}  = flags_q;
endmodule
